line_clear_engine: RTL and testbench



---
 rtl/line_clear_engine_if.sv | 13 +
 rtl/line_clear_engine.sv | 172 +++++++++++++++++
 tb/tb_line_clear_engine.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_engine_if.sv
// rtl/line_clear_engine_if.sv - shared column-RAM bus between the line-clear engine and the board RAMs
interface line_clear_engine_if #(
    parameter int COLS    = 10,
    parameter int COLOR_W = 24
);
    logic [4:0]              ram_addr;
    logic [COLS*COLOR_W-1:0] ram_rdata;
    logic [COLS*COLOR_W-1:0] ram_wdata;
    logic [COLS-1:0]         ram_we;

    modport master (output ram_addr, output ram_wdata, output ram_we, input  ram_rdata);
    modport slave  (input  ram_addr, input  ram_wdata, input  ram_we, output ram_rdata);
endinterface

// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - bottom-up full-row removal and in-place board compaction; optional LINE_CLEAR_SCORE_EN scoring
module line_clear_engine #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int COLOR_W = 24,
    parameter int RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
`ifdef LINE_CLEAR_SCORE_EN
    output logic [19:0] score,
    output logic [9:0]  total_lines,
    output logic [5:0]  level,
`endif
    line_clear_engine_if.master ram
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, WRITE, CLEAR, DONE} state_t;

    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state;
    logic [WCW-1:0]  wait_cnt;
    logic [5:0]      rd_row, wr_row;
    logic [5:0]      rd_dec, wr_dec;
    logic            row_full;

    // Pointers are 6 bits so that stepping below row 0 sets bit 5 (exhausted).
    assign rd_dec = rd_row - 6'd1;
    assign wr_dec = wr_row - 6'd1;

    always_comb begin
        row_full = 1'b1;
        for (int i = 0; i < COLS; i++)
            if (ram.ram_rdata[i*COLOR_W +: COLOR_W] == '0) row_full = 1'b0;
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [10:0] base;
    logic [16:0] score_add;
    logic [20:0] score_sum;
    logic [10:0] total_sum;
    logic [9:0]  total_new;
    logic [9:0]  level_calc;

    always_comb begin
        case (lines_cleared)
            5'd0:    base = 11'd0;
            5'd1:    base = 11'd40;
            5'd2:    base = 11'd100;
            5'd3:    base = 11'd300;
            default: base = 11'd1200;
        endcase
        score_add  = 17'(base) * (17'(level) + 17'd1);
        score_sum  = 21'(score) + 21'(score_add);
        total_sum  = {1'b0, total_lines} + 11'(lines_cleared);
        total_new  = total_sum[10] ? 10'h3FF : total_sum[9:0];
        level_calc = total_new / 10'd10;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            rd_row        <= '0;
            wr_row        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            ram.ram_addr  <= '0;
            ram.ram_we    <= '0;
            ram.ram_wdata <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score         <= '0;
            total_lines   <= '0;
            level         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_row        <= 6'(ROWS - 1);
                        wr_row        <= 6'(ROWS - 1);
                        lines_cleared <= '0;
                        busy          <= 1'b1;
                        ram.ram_addr  <= 5'(ROWS - 1);
                        ram.ram_we    <= '0;
                        state         <= READ;
                    end
                end
                READ: begin
                    wait_cnt <= WCW'(RD_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= EVAL;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                EVAL: begin
                    if (row_full) begin
                        lines_cleared <= lines_cleared + 5'd1;
                        rd_row        <= rd_dec;
                        if (rd_dec[5]) begin
                            ram.ram_addr  <= wr_row[4:0];
                            ram.ram_we    <= '1;
                            ram.ram_wdata <= '0;
                            state         <= CLEAR;
                        end else begin
                            ram.ram_addr <= rd_dec[4:0];
                            state        <= READ;
                        end
                    end else if (wr_row == rd_row) begin
                        // Nothing removed yet, so an exhausted scan has nothing to clear.
                        rd_row <= rd_dec;
                        wr_row <= wr_dec;
                        if (rd_dec[5]) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ram.ram_addr <= rd_dec[4:0];
                            state        <= READ;
                        end
                    end else begin
                        ram.ram_addr  <= wr_row[4:0];
                        ram.ram_we    <= '1;
                        ram.ram_wdata <= ram.ram_rdata;
                        state         <= WRITE;
                    end
                end
                WRITE: begin
                    rd_row <= rd_dec;
                    wr_row <= wr_dec;
                    if (rd_dec[5]) begin
                        ram.ram_addr  <= wr_dec[4:0];
                        ram.ram_wdata <= '0;
                        state         <= CLEAR;
                    end else begin
                        ram.ram_addr <= rd_dec[4:0];
                        ram.ram_we   <= '0;
                        state        <= READ;
                    end
                end
                CLEAR: begin
                    wr_row <= wr_dec;
                    if (wr_row == 6'd0) begin
                        ram.ram_we <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        ram.ram_addr <= wr_dec[4:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
`ifdef LINE_CLEAR_SCORE_EN
                    score       <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
                    total_lines <= total_new;
                    level       <= (level_calc > 10'd63) ? 6'd63 : level_calc[5:0];
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - directed self-checking bench for line_clear_engine with a column-RAM model
module tb_line_clear_engine;
    localparam int ROWS = 20, COLS = 10, CW = 24, RD_LAT = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [4:0] lines_cleared;
`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0] score;
    logic [9:0]  total_lines;
    logic [5:0]  level;
`endif

    line_clear_engine_if #(.COLS(COLS), .COLOR_W(CW)) bus ();

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .COLOR_W(CW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared),
`ifdef LINE_CLEAR_SCORE_EN
        .score(score), .total_lines(total_lines), .level(level),
`endif
        .ram(bus.master)
    );

    always #10 clk = ~clk;

    logic [CW-1:0] mem      [ROWS][COLS];
    logic [CW-1:0] init_mem [ROWS][COLS];
    logic [CW-1:0] exp_mem  [ROWS][COLS];
    logic          load = 1'b0;
    logic          cnt_clr = 1'b0;
    int            n_writes, n_busy, n_done, n_we_idle;
    int            n_tests = 0, n_fail = 0;

    // Synchronous-read column RAMs: one cycle from address to rdata.
    always @(posedge clk) begin
        if (load) begin
            mem <= init_mem;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (bus.ram_we[c] && bus.ram_addr < 5'(ROWS))
                    mem[bus.ram_addr][c] <= bus.ram_wdata[c*CW +: CW];
                bus.ram_rdata[c*CW +: CW] <= (bus.ram_addr < 5'(ROWS)) ? mem[bus.ram_addr][c] : '0;
            end
        end
    end

    always @(posedge clk) begin
        if (cnt_clr) begin
            n_writes <= 0; n_busy <= 0; n_done <= 0;
        end else begin
            if (bus.ram_we != '0) n_writes <= n_writes + 1;
            if (busy)             n_busy   <= n_busy + 1;
            if (done)             n_done   <= n_done + 1;
        end
        if (bus.ram_we != '0 && !busy) n_we_idle <= n_we_idle + 1;
    end
    initial n_we_idle = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, want);
        end
    endtask

    task automatic clear_boards();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                init_mem[r][c] = '0;
                exp_mem[r][c]  = '0;
            end
    endtask

    task automatic fill_row(input int r);
        for (int c = 0; c < COLS; c++) init_mem[r][c] = 24'h100000 | CW'(r << 8) | CW'(c + 1);
    endtask

    task automatic load_board();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic check_board(input string tag);
        int bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r][c] !== exp_mem[r][c]) bad++;
        chk(tag, bad, 0);
    endtask

    // poke > 0 pulses start that many cycles into the run; at_done pulses start alongside done.
    task automatic run_scan(input int poke, input bit at_done);
        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) begin cnt_clr = 1'b0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        for (int i = 1; i < 400 && !done; i++) begin
            start = (i == poke);
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) chk("done_timeout", done, 1);
        if (at_done) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (at_done) chk("start_at_done_ignored", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        clear_boards();
        load_board();
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_wdata", |bus.ram_wdata, 0);
        rst_n = 1'b1;

        // Empty board: 20 kept rows at 3 cycles each, no writes.
        run_scan(0, 0);
        chk("empty_lines", lines_cleared, 0);
        chk("empty_busy_cycles", n_busy, 60);
        chk("empty_writes", n_writes, 0);
        chk("empty_done_count", n_done, 1);
        check_board("empty_board");

        // One full row under a single-cell row.
        clear_boards();
        fill_row(19);
        init_mem[18][3] = 24'hFF99FF;
        exp_mem[19][3]  = 24'hFF99FF;
        load_board();
        run_scan(0, 0);
        chk("one_lines", lines_cleared, 1);
        chk("one_writes", n_writes, 20);
        chk("one_busy_cycles", n_busy, 80);
        check_board("one_board");

        // Two interleaved full rows.
        clear_boards();
        fill_row(19);
        fill_row(17);
        init_mem[18][0] = 24'hA0A0A0;
        init_mem[16][9] = 24'h0B0B0B;
        exp_mem[19][0]  = 24'hA0A0A0;
        exp_mem[18][9]  = 24'h0B0B0B;
        load_board();
        run_scan(0, 0);
        chk("two_lines", lines_cleared, 2);
        chk("two_writes", n_writes, 20);
        chk("two_busy_cycles", n_busy, 80);
        check_board("two_board");

        // Whole board full.
        clear_boards();
        for (int r = 0; r < ROWS; r++) fill_row(r);
        load_board();
        run_scan(0, 0);
        chk("all_lines", lines_cleared, 20);
        chk("all_done_count", n_done, 1);
        chk("all_writes", n_writes, 20);
        chk("all_busy_cycles", n_busy, 80);
        check_board("all_board");

        // start while busy and start coincident with done are both ignored.
        clear_boards();
        fill_row(19);
        init_mem[18][3] = 24'hFF99FF;
        exp_mem[19][3]  = 24'hFF99FF;
        load_board();
        run_scan(10, 1);
        chk("restart_lines", lines_cleared, 1);
        chk("restart_busy_cycles", n_busy, 80);
        chk("restart_done_count", n_done, 1);
        check_board("restart_board");

        // Reset in the middle of the CLEAR phase.
        clear_boards();
        for (int r = 0; r < ROWS; r++) fill_row(r);
        load_board();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 200 && bus.ram_we == '0; i++) @(negedge clk);
        chk("clear_reached", bus.ram_we, 10'h3FF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_we", bus.ram_we, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_lines", lines_cleared, 0);
        rst_n = 1'b1;

        // Bottom-row clears of 4, 4, 2 and 1 lines for the score sequence.
        for (int k = 0; k < 4; k++) begin
            int nrows;
            nrows = (k < 2) ? 4 : (k == 2) ? 2 : 1;
            clear_boards();
            for (int r = 0; r < nrows; r++) fill_row(ROWS - 1 - r);
            load_board();
            run_scan(0, 0);
            chk("seq_lines", lines_cleared, nrows);
            check_board("seq_board");
`ifdef LINE_CLEAR_SCORE_EN
            case (k)
                0: chk("score_4_at_lvl0", score, 1200);
                1: begin chk("score_8", score, 2400); chk("level_at_8", level, 0); end
                2: begin chk("score_10", score, 2500); chk("total_10", total_lines, 10); chk("level_at_10", level, 1); end
                default: chk("score_1_at_lvl1", score, 2580);
            endcase
`endif
        end

        chk("we_outside_busy", n_we_idle, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
